// File: rtl/hit_arbiter.sv
// Round-robin hit scheduler: grants one combat hit per clock, applies saturating
// damage to the char/boss HP registers and enforces per-target iframes on vsync.
module hit_arbiter #(
  parameter int               N_REQ        = 4,
  parameter logic [N_REQ-1:0] TGT_MASK     = 4'b0011,
  parameter int               CHAR_IFRAMES = 30,
  parameter int               BOSS_IFRAMES = 4,
  parameter int               BOSS_HP_INIT = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_start,
  input  logic               game_active,
  input  logic               vsync,
  input  logic [3:0]         char_hp_max,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [4*N_REQ-1:0] req_dmg,
  output logic [N_REQ-1:0]   req_ack,
  output logic               req_applied,
  output logic [3:0]         current_health,
  output logic [6:0]         boss_hp,
  output logic               char_hit,
  output logic               boss_hit,
  output logic               char_invuln,
  output logic               round_over,
  output logic [1:0]         dbg_state
);

  localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW_C = $clog2(CHAR_IFRAMES + 1);
  localparam int CW_B = $clog2(BOSS_IFRAMES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    ptr;
  logic [CW_C-1:0]  char_cnt;
  logic [CW_B-1:0]  boss_cnt;
  logic             vsync_q;
  logic [3:0]       hp_max_q;

  logic [N_REQ-1:0] eligible;
  logic             win_found;
  logic [PW-1:0]    win_idx;
  logic [3:0]       win_dmg;
  logic             win_boss;
  logic             vs_edge;
  logic             char_free, boss_free, win_free;
  logic             grant_en;
  logic [3:0]       char_sub;
  logic [6:0]       boss_sub;

  // Handshake: req_valid is a level held by the requester until it sees a
  // one-cycle req_ack; the previous cycle's ack masks that requester so it is
  // never granted twice for one request.
  always_comb begin
    logic [PW-1:0] idx;
    int            idx_i;
    eligible  = req_valid & ~req_ack;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_i = int'(ptr) + k;
      if (idx_i >= N_REQ) idx_i = idx_i - N_REQ;
      idx = PW'(idx_i);
      if (!win_found && eligible[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_comb begin
    win_dmg  = '0;
    win_boss = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (PW'(k) == win_idx) begin
        win_dmg  = req_dmg[4*k +: 4];
        win_boss = TGT_MASK[k];
      end
    end
  end

  assign vs_edge = vsync & ~vsync_q;
  // A counter that expires on this very frame edge no longer protects its target.
  assign char_free = (char_cnt == '0) || (char_cnt == CW_C'(1) && vs_edge);
  assign boss_free = (boss_cnt == '0) || (boss_cnt == CW_B'(1) && vs_edge);
  assign win_free  = win_boss ? boss_free : char_free;
  assign grant_en  = (state == RUN) && game_active && !game_start &&
                     (current_health != '0) && (boss_hp != '0) && win_found;
  assign char_sub  = (current_health > win_dmg) ? current_health - win_dmg : 4'd0;
  assign boss_sub  = (boss_hp > {3'b000, win_dmg}) ? boss_hp - {3'b000, win_dmg} : 7'd0;

  always_comb begin
    state_nxt = state;
    if (game_start) begin
      state_nxt = ARM;
    end else begin
      case (state)
        IDLE: state_nxt = IDLE;
        ARM:  state_nxt = RUN;
        RUN: begin
          if (!game_active) state_nxt = IDLE;
          else if (current_health == '0 || boss_hp == '0) state_nxt = DONE;
        end
        DONE: if (!game_active) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      ptr            <= '0;
      char_cnt       <= '0;
      boss_cnt       <= '0;
      vsync_q        <= 1'b0;
      hp_max_q       <= '0;
      req_ack        <= '0;
      req_applied    <= 1'b0;
      current_health <= '0;
      boss_hp        <= '0;
      char_hit       <= 1'b0;
      boss_hit       <= 1'b0;
    end else begin
      state       <= state_nxt;
      vsync_q     <= vsync;
      req_ack     <= '0;
      req_applied <= 1'b0;
      char_hit    <= 1'b0;
      boss_hit    <= 1'b0;
      if (game_start) hp_max_q <= char_hp_max;
      if (vs_edge && char_cnt != '0) char_cnt <= char_cnt - CW_C'(1);
      if (vs_edge && boss_cnt != '0) boss_cnt <= boss_cnt - CW_B'(1);
      // Loads below are written after the decrement so they take priority.
      if (state == ARM) begin
        current_health <= hp_max_q;
        boss_hp        <= 7'(BOSS_HP_INIT);
        char_cnt       <= '0;
        boss_cnt       <= '0;
        ptr            <= '0;
      end else if (grant_en) begin
        req_ack     <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
        req_applied <= win_free;
        ptr         <= (win_idx == PW'(N_REQ-1)) ? '0 : win_idx + PW'(1);
        if (win_free && win_boss) begin
          boss_hp  <= boss_sub;
          boss_hit <= 1'b1;
          boss_cnt <= CW_B'(BOSS_IFRAMES);
        end else if (win_free) begin
          current_health <= char_sub;
          char_hit       <= 1'b1;
          char_cnt       <= CW_C'(CHAR_IFRAMES);
        end
      end
    end
  end

  assign char_invuln = (char_cnt != '0);
  assign round_over  = (state == DONE);
  assign dbg_state   = state;

endmodule

// File: tb/tb_hit_arbiter.sv
// Directed bench for hit_arbiter: vector table for the basic round, then
// hand-written sequences for iframes, round-robin order, death and reset.
module tb_hit_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        game_start, game_active, vsync;
  logic [3:0]  char_hp_max;
  logic [3:0]  req_valid;
  logic [15:0] req_dmg;
  logic [3:0]  req_ack;
  logic        req_applied;
  logic [3:0]  current_health;
  logic [6:0]  boss_hp;
  logic        char_hit, boss_hit, char_invuln, round_over;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];

  hit_arbiter dut (
    .clk(clk), .rst(rst), .game_start(game_start), .game_active(game_active),
    .vsync(vsync), .char_hp_max(char_hp_max), .req_valid(req_valid),
    .req_dmg(req_dmg), .req_ack(req_ack), .req_applied(req_applied),
    .current_health(current_health), .boss_hp(boss_hp), .char_hit(char_hit),
    .boss_hit(boss_hit), .char_invuln(char_invuln), .round_over(round_over),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       gs, ga, vs;
    logic [3:0] hpmax, rv;
    logic [15:0] dmg;
    logic [3:0] e_ack;
    logic       e_app;
    logic [3:0] e_hp;
    logic [6:0] e_bhp;
    logic       e_ch, e_bh, e_inv, e_ro;
    logic [1:0] e_st;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic vsync_edges(input int n, input logic chk_inv);
    for (int i = 0; i < n; i++) begin
      vsync = 1'b1;
      tick();
      if (chk_inv) chk("invuln_during_iframes", char_invuln, 1);
      vsync = 1'b0;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    //             gs ga vs hpmax rv       dmg       ack      app hp  bhp  ch bh inv ro st
    vecs[0] = '{0, 0, 0, 4'd0, 4'b0000, 16'h0000, 4'b0000, 0, 4'd0, 7'd0,   0, 0, 0, 0, 2'd0};
    vecs[1] = '{1, 1, 0, 4'd6, 4'b0000, 16'h0000, 4'b0000, 0, 4'd0, 7'd0,   0, 0, 0, 0, 2'd1};
    vecs[2] = '{0, 1, 0, 4'd0, 4'b0000, 16'h0000, 4'b0000, 0, 4'd6, 7'd100, 0, 0, 0, 0, 2'd2};
    vecs[3] = '{0, 1, 0, 4'd0, 4'b0001, 16'h0005, 4'b0001, 1, 4'd6, 7'd95,  0, 1, 0, 0, 2'd2};
    vecs[4] = '{0, 1, 0, 4'd0, 4'b0000, 16'h0005, 4'b0000, 0, 4'd6, 7'd95,  0, 0, 0, 0, 2'd2};
    vecs[5] = '{0, 1, 0, 4'd0, 4'b0001, 16'h0005, 4'b0001, 0, 4'd6, 7'd95,  0, 0, 0, 0, 2'd2};
    vecs[6] = '{0, 1, 0, 4'd0, 4'b0000, 16'h0000, 4'b0000, 0, 4'd6, 7'd95,  0, 0, 0, 0, 2'd2};
    vecs[7] = '{0, 1, 0, 4'd0, 4'b0100, 16'h0300, 4'b0100, 1, 4'd3, 7'd95,  1, 0, 1, 0, 2'd2};
    vecs[8] = '{0, 1, 0, 4'd0, 4'b0000, 16'h0000, 4'b0000, 0, 4'd3, 7'd95,  0, 0, 1, 0, 2'd2};

    rst = 1'b1; game_start = 0; game_active = 0; vsync = 0;
    char_hp_max = 0; req_valid = 0; req_dmg = 0;
    tick(); tick();
    chk("reset_ack", req_ack, 0);
    chk("reset_health", current_health, 0);
    chk("reset_boss_hp", boss_hp, 0);
    chk("reset_state", dbg_state, 0);
    rst = 1'b0;

    // Basic round from the vector table
    for (int i = 0; i < 9; i++) begin
      game_start = vecs[i].gs; game_active = vecs[i].ga; vsync = vecs[i].vs;
      char_hp_max = vecs[i].hpmax; req_valid = vecs[i].rv; req_dmg = vecs[i].dmg;
      tick();
      chk($sformatf("v%0d_ack", i), req_ack, vecs[i].e_ack);
      chk($sformatf("v%0d_applied", i), req_applied, vecs[i].e_app);
      chk($sformatf("v%0d_health", i), current_health, vecs[i].e_hp);
      chk($sformatf("v%0d_boss_hp", i), boss_hp, vecs[i].e_bhp);
      chk($sformatf("v%0d_char_hit", i), char_hit, vecs[i].e_ch);
      chk($sformatf("v%0d_boss_hit", i), boss_hit, vecs[i].e_bh);
      chk($sformatf("v%0d_invuln", i), char_invuln, vecs[i].e_inv);
      chk($sformatf("v%0d_round_over", i), round_over, vecs[i].e_ro);
      chk($sformatf("v%0d_state", i), dbg_state, vecs[i].e_st);
    end

    // Char iframes: high through 29 edges, low right after the 30th
    vsync_edges(29, 1'b1);
    vsync = 1'b1;
    tick();
    chk("invuln_drop_30th", char_invuln, 0);
    vsync = 1'b0;
    tick();

    // New char hit (dmg 1), then a dmg-0 request landing on the 30th edge cycle
    req_valid = 4'b1000; req_dmg = 16'h1000;
    tick();
    chk("hit2_ack", req_ack, 4'b1000);
    chk("hit2_applied", req_applied, 1);
    chk("hit2_health", current_health, 2);
    req_valid = 4'b0000;
    tick();
    vsync_edges(29, 1'b0);
    vsync = 1'b1; req_valid = 4'b1000; req_dmg = 16'h0000;
    tick();
    chk("edge30_ack", req_ack, 4'b1000);
    chk("edge30_applied", req_applied, 1);
    chk("edge30_dmg0_health", current_health, 2);
    chk("edge30_reload_invuln", char_invuln, 1);
    vsync = 1'b0; req_valid = 4'b0000;
    tick();

    // Round-robin: all four held, acks expected 0,1,2,3
    exp_q.push_back({1'b1, 4'b0001});
    exp_q.push_back({1'b0, 4'b0010});
    exp_q.push_back({1'b0, 4'b0100});
    exp_q.push_back({1'b0, 4'b1000});
    begin
      logic [3:0] prev;
      logic [4:0] e;
      prev = '0;
      req_valid = 4'b1111; req_dmg = 16'h1111;
      for (int c = 0; c < 12 && exp_q.size() > 0; c++) begin
        tick();
        if (req_ack != 0) begin
          e = exp_q.pop_front();
          chk("rr_ack_order", {req_applied, req_ack}, e);
          chk("rr_no_repeat", req_ack & prev, 0);
          req_valid = req_valid & ~req_ack;
        end
        prev = req_ack;
      end
      if (exp_q.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL rr_timeout pending=%0d expected=0", exp_q.size());
        exp_q.delete();
      end
    end
    chk("rr_boss_hp", boss_hp, 94);
    chk("rr_health", current_health, 2);
    req_valid = 4'b0011;
    tick();
    chk("rr_wrap_first", req_ack, 4'b0001);
    req_valid = 4'b0010;
    tick();
    chk("rr_wrap_second", req_ack, 4'b0010);
    req_valid = 4'b0000;
    tick();

    // Death: clear iframes, then health 2 takes dmg 7 -> saturates at 0
    vsync_edges(30, 1'b0);
    req_valid = 4'b0100; req_dmg = 16'h0700;
    tick();
    chk("death_ack", req_ack, 4'b0100);
    chk("death_health", current_health, 0);
    chk("death_char_hit", char_hit, 1);
    req_valid = 4'b1111; req_dmg = 16'h1111;
    tick();
    chk("death_round_over", round_over, 1);
    chk("death_state", dbg_state, 3);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("done_no_ack", req_ack, 0);
    end
    game_active = 0; req_valid = 0;
    tick();
    chk("done_to_idle", dbg_state, 0);

    // Reset mid-round with requests pending
    game_start = 1; game_active = 1; char_hp_max = 4'd9;
    tick();
    game_start = 0; char_hp_max = 4'd0;
    tick();
    req_valid = 4'b1111; req_dmg = 16'h1111;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_ack", req_ack, 0);
    chk("arst_health", current_health, 0);
    chk("arst_boss_hp", boss_hp, 0);
    chk("arst_invuln", char_invuln, 0);
    chk("arst_state", dbg_state, 0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("post_rst_no_ack", req_ack, 0);
    end
    req_valid = 4'b0000;
    game_start = 1; char_hp_max = 4'd9;
    tick();
    game_start = 0;
    tick();
    chk("restart_health", current_health, 9);
    chk("restart_boss_hp", boss_hp, 100);
    req_valid = 4'b0001; req_dmg = 16'h0002;
    tick();
    chk("restart_ack", req_ack, 4'b0001);
    chk("restart_boss_dmg", boss_hp, 98);
    req_valid = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hit_arbiter.md
Name: hit_arbiter

Overview:
- Central damage scheduler for the gameplay datapath.
- Collects hit requests from combat requesters (char melee, char projectile, boss contact, boss projectile) and grants at most one per clock, round-robin.
- Applies saturating damage to the single authoritative char HP and boss HP registers and enforces per-target invulnerability frames counted on vsync.
- Sits between the char/boss modules and game_fsm, which consumes its HP outputs.

Parameters:
- N_REQ, 4, number of hit requesters.
- TGT_MASK, 4'b0011, bit i = 1 means requester i targets the boss; 0 means it targets the char.
- CHAR_IFRAMES, 30, char invulnerability length in frames after a hit.
- BOSS_IFRAMES, 4, boss invulnerability length in frames after a hit.
- BOSS_HP_INIT, 100, boss HP loaded at game start (7-bit).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous active-high reset.
- game_start  in  1  one-cycle pulse that starts a round.
- game_active  in  1  high while gameplay runs.
- vsync  in  1  VGA vsync; each rising edge is one frame tick.
- char_hp_max  in  4  starting char HP (class-dependent), sampled on game_start.
- req_valid  in  N_REQ  level hit request, held until acked.
- req_dmg  in  4*N_REQ  damage per requester; bits [4i+3:4i] belong to requester i.
- req_ack  out  N_REQ  one-cycle acknowledge, one-hot or zero.
- req_applied  out  1  qualifies req_ack: 1 = damage applied, 0 = discarded by iframes.
- current_health  out  4  char HP.
- boss_hp  out  7  boss HP.
- char_hit  out  1  one-cycle pulse when char damage is applied.
- boss_hit  out  1  one-cycle pulse when boss damage is applied.
- char_invuln  out  1  char iframe counter nonzero.
- round_over  out  1  high in DONE state.

Behaviour:
- Reset: state IDLE. All outputs 0 except current_health = 0 and boss_hp = 0. Round-robin pointer = 0; iframe counters = 0; vsync edge register = 0.
- FSM:
  - IDLE -> ARM on game_start.
  - ARM (1 cycle): current_health <= char_hp_max; boss_hp <= BOSS_HP_INIT; counters cleared; pointer = 0. ARM -> RUN.
  - RUN -> DONE when current_health == 0 or boss_hp == 0 after an update.
  - RUN -> IDLE if game_active drops.
  - DONE -> IDLE when game_active == 0.
  - game_start in any state -> ARM (restart).
- Arbitration, RUN only:
  - Eligible = req_valid & ~last_grant_mask. last_grant_mask is the one-hot grant registered in the previous cycle, which prevents regranting a requester that has not yet seen its ack.
  - Winner = first eligible index at or after the pointer, wrapping.
  - req_ack registered: asserted in cycle N+1 for a request granted from state sampled at cycle N. Pointer <= winner + 1 mod N_REQ.
  - No requests are granted in IDLE, ARM or DONE; req_ack = 0.
- Damage:
  - If the winner's target iframe counter == 0: HP <= HP - dmg, saturating at 0. req_applied = 1. The matching hit pulse fires in the same cycle as req_ack. Target counter is loaded with CHAR_IFRAMES or BOSS_IFRAMES.
  - If the counter is nonzero: the request is acked with req_applied = 0 and HP is unchanged.
  - dmg = 0: ack with req_applied = 1, HP unchanged, counter still loaded.
- Iframes: vsync rising edge detected with one register. Each counter decrements by 1 per edge, stopping at 0. A load in the same cycle as an edge takes priority over the decrement.
- Simultaneous hits to both targets are serialized by the arbiter, one per cycle.
- Reset mid-round returns everything to reset values immediately (asynchronous).

Test Plan:
- Reset, then game_start with char_hp_max = 6 -> after 2 cycles: current_health = 6, boss_hp = 100, state RUN, req_ack = 0.
- req_valid[0] with dmg 5 held until ack -> req_ack = 0001 one cycle, req_applied = 1, boss_hit pulse, boss_hp = 95. A second request before 4 vsync edges gives req_applied = 0 and boss_hp stays 95.
- req_valid = 1111 held, all dmg 1, iframes 0 -> acks arrive in order 0, 1, 2, 3 on alternating-free cycles. No requester is acked twice in consecutive cycles. Pointer wraps to 0.
- current_health = 2, char request dmg 7 -> current_health = 0, round_over = 1 next cycle, further requests are not acked.
- Char hit, then count vsync edges -> char_invuln stays high for exactly 30 rising edges, then drops. A request on the 30th edge cycle is applied.
- Assert rst mid-round with requests pending -> all outputs 0 asynchronously. After release, no ack occurs until game_start.
